// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg
//   Shared types and constants for the GPIO APB arbiter slice.
//   - arb_state_e : arbiter FSM states (IDLE, SETUP, ACCESS)
//   - APB_ADDR_W / APB_DATA_W / APB_STRB_W : APB bus field widths
package gpio_arb_pkg;

   localparam int APB_ADDR_W = 12;
   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_e;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// gpio_rr_arbiter
//   Combinational round-robin picker. Searches the request vector starting
//   at (last_grant + 1) mod NUM_REQ and wraps around; the first set request
//   found wins.
// Ports:
//   req        in  [NUM_REQ-1:0]  request vector
//   last_grant in  [IDX_W-1:0]    index granted most recently
//   grant      out [NUM_REQ-1:0]  one-hot winner (all zero when no request)
//   grant_idx  out [IDX_W-1:0]    binary index of the winner
module gpio_rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   // One extra bit so last_grant + NUM_REQ never overflows before the wrap.
   logic [IDX_W:0]     sum_w    [NUM_REQ];
   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;

   // Slot gi holds the requester visited at search offset gi+1.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign sum_w[gi]    = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum_w[gi] >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(sum_w[gi] - (IDX_W+1)'(NUM_REQ))
                            : sum_w[gi][IDX_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
   end

   // Walk from the far end so the nearest hit is the one left standing.
   always_comb begin
      grant_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            grant_idx = cand_idx[k];
         end
      end
      grant = '0;
      if (|cand_hit) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter
//   Arbitrates NUM_REQ requesters onto a single APB master port that feeds
//   gpio_controller. One transfer at a time: IDLE -> SETUP -> ACCESS -> IDLE.
//   Optional build macro GPIO_APB_ARB_TIMEOUT_EN adds an ACCESS-phase
//   watchdog that aborts after TIMEOUT_CYCLES cycles without pready.
// Ports:
//   sys_clk, rst_n                      clock, synchronous active-low reset
//   req_valid / req_ready               per-requester request / accept strobe
//   req_addr/write/wdata/strb           per-requester transfer fields
//   resp_valid, resp_rdata, resp_err    one-hot completion + shared response
//   paddr..pwdata (out), prdata/pready/pslverr (in)   APB master
module gpio_apb_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                 sys_clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0][APB_ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]                   req_write,
   input  logic [NUM_REQ-1:0][APB_DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ-1:0][APB_STRB_W-1:0]   req_strb,
   output logic [NUM_REQ-1:0]                   resp_valid,
   output logic [APB_DATA_W-1:0]                resp_rdata,
   output logic                                 resp_err,
   output logic [APB_ADDR_W-1:0]                paddr,
   output logic                                 pwrite,
   output logic                                 psel,
   output logic                                 penable,
   output logic [APB_STRB_W-1:0]                pstrb,
   output logic [APB_DATA_W-1:0]                pwdata,
   input  logic [APB_DATA_W-1:0]                prdata,
   input  logic                                 pready,
   input  logic                                 pslverr
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("gpio_apb_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("gpio_apb_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   arb_state_e              state_reg;
   logic [IDX_W-1:0]        last_grant_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [NUM_REQ-1:0]      req_ready_reg;
   logic [NUM_REQ-1:0]      resp_valid_reg;
   logic [APB_DATA_W-1:0]   resp_rdata_reg;
   logic                    resp_err_reg;
   logic [APB_ADDR_W-1:0]   paddr_reg;
   logic                    pwrite_reg;
   logic                    psel_reg;
   logic                    penable_reg;
   logic [APB_STRB_W-1:0]   pstrb_reg;
   logic [APB_DATA_W-1:0]   pwdata_reg;

   logic [NUM_REQ-1:0]      grant_onehot;
   logic [IDX_W-1:0]        grant_idx;
   logic [NUM_REQ-1:0]      idx_onehot;

`ifdef GPIO_APB_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]         to_cnt_reg;
`endif

   gpio_rr_arbiter #(
      .NUM_REQ   (NUM_REQ)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_reg),
      .grant      (grant_onehot),
      .grant_idx  (grant_idx)
   );

   // Completion strobe is rebuilt from the latched index, not from req_valid.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_idx_onehot
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= IDX_W'(NUM_REQ - 1);
         idx_reg        <= '0;
         req_ready_reg  <= '0;
         resp_valid_reg <= '0;
         resp_rdata_reg <= '0;
         resp_err_reg   <= 1'b0;
         paddr_reg      <= '0;
         pwrite_reg     <= 1'b0;
         psel_reg       <= 1'b0;
         penable_reg    <= 1'b0;
         pstrb_reg      <= '0;
         pwdata_reg     <= '0;
`ifdef GPIO_APB_ARB_TIMEOUT_EN
         to_cnt_reg     <= '0;
`endif
      end else begin
         // Both strobes are single-cycle pulses.
         req_ready_reg  <= '0;
         resp_valid_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (|req_valid) begin
                  req_ready_reg <= grant_onehot;
                  idx_reg       <= grant_idx;
                  paddr_reg     <= req_addr[grant_idx];
                  pwrite_reg    <= req_write[grant_idx];
                  pwdata_reg    <= req_wdata[grant_idx];
                  // Reads never carry byte strobes on the bus.
                  pstrb_reg     <= req_write[grant_idx] ? req_strb[grant_idx] : '0;
                  psel_reg      <= 1'b1;
                  penable_reg   <= 1'b0;
                  state_reg     <= SETUP;
               end
            end
            SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ACCESS;
`ifdef GPIO_APB_ARB_TIMEOUT_EN
               to_cnt_reg  <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  psel_reg       <= 1'b0;
                  penable_reg    <= 1'b0;
                  resp_valid_reg <= idx_onehot;
                  resp_rdata_reg <= pwrite_reg ? '0 : prdata;
                  resp_err_reg   <= pslverr;
                  last_grant_reg <= idx_reg;
                  state_reg      <= IDLE;
               end
`ifdef GPIO_APB_ARB_TIMEOUT_EN
               // Counter holds the number of ACCESS cycles already spent
               // without pready; this one is the last allowed.
               else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  psel_reg       <= 1'b0;
                  penable_reg    <= 1'b0;
                  resp_valid_reg <= idx_onehot;
                  resp_rdata_reg <= '0;
                  resp_err_reg   <= 1'b1;
                  last_grant_reg <= idx_reg;
                  state_reg      <= IDLE;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
`endif
            end
            default: begin
               psel_reg    <= 1'b0;
               penable_reg <= 1'b0;
               state_reg   <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = resp_rdata_reg;
   assign resp_err   = resp_err_reg;
   assign paddr      = paddr_reg;
   assign pwrite     = pwrite_reg;
   assign psel       = psel_reg;
   assign penable    = penable_reg;
   assign pstrb      = pstrb_reg;
   assign pwdata     = pwdata_reg;

endmodule

// File: doc/gpio_apb_arbiter.md
GPIO_APB_ARBITER -- requirements
Module: gpio_apb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase cycles allowed before abort (timeout build only).
REQ-003 The block SHALL have port sys_clk  input  1  single clock, all logic on posedge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous active-low reset, sampled on posedge sys_clk.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester transfer request.
REQ-006 The block SHALL have port req_ready  output  NUM_REQ  one-hot accept strobe, one cycle.
REQ-007 The block SHALL have ports req_addr  input  NUM_REQ x 12, req_write  input  NUM_REQ, req_wdata  input  NUM_REQ x 32, req_strb  input  NUM_REQ x 4: per-requester transfer fields.
REQ-008 The block SHALL have port resp_valid  output  NUM_REQ  one-hot completion strobe, one cycle.
REQ-009 The block SHALL have ports resp_rdata  output  32 and resp_err  output  1: shared response, qualified by resp_valid.
REQ-010 The block SHALL have APB master ports paddr  output  12, pwrite  output  1, psel  output  1, penable  output  1, pstrb  output  4, pwdata  output  32, prdata  input  32, pready  input  1, pslverr  input  1, connecting to gpio_controller.

Function
REQ-011 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-012 In IDLE with any req_valid set, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-013 On grant, the block SHALL pulse req_ready for the winner for one cycle, latch its addr/write/wdata/strb and the grant index, and enter SETUP.
REQ-014 SETUP SHALL last exactly one cycle with psel=1, penable=0, and APB fields driven from the latch.
REQ-015 ACCESS SHALL drive psel=1 and penable=1, holding all APB fields stable, until pready=1.
REQ-016 On pready=1 in ACCESS, the block SHALL, in the next cycle, drop psel/penable, pulse resp_valid for the granted index, drive resp_rdata=prdata (0 for writes) and resp_err=pslverr, update last_grant, and enter IDLE.
REQ-017 Latency SHALL be: accept cycle N, SETUP N+1, ACCESS N+2, and resp_valid N+3 for zero-wait pready.
REQ-018 At least one IDLE cycle with psel=0 SHALL separate consecutive transfers; the next grant may occur in the same cycle as resp_valid.
REQ-019 req_valid changes during SETUP/ACCESS SHALL NOT affect the transfer in flight.
REQ-020 A request deasserted before grant SHALL be dropped with no response.
REQ-021 pstrb SHALL be driven as 4'b0000 for reads.
REQ-022 req_ready and resp_valid SHALL never have more than one bit set.

Reset
REQ-023 When rst_n=0, the block SHALL enter IDLE, set last_grant=NUM_REQ-1 (so requester 0 wins first), and drive every output to 0 (psel, penable, req_ready, resp_valid, resp_err, resp_rdata, paddr, pwdata, pstrb, pwrite).
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no resp_valid.

Configuration
REQ-025 With GPIO_APB_ARB_TIMEOUT_EN defined, an ACCESS cycle counter SHALL abort the transfer after TIMEOUT_CYCLES cycles without pready.
REQ-026 On timeout abort, the block SHALL drop psel/penable, pulse resp_valid with resp_err=1 and resp_rdata=0, and enter IDLE.
REQ-027 Without GPIO_APB_ARB_TIMEOUT_EN, ACCESS SHALL wait indefinitely, and neither the counter nor the TIMEOUT_CYCLES logic SHALL be present.

Structure
REQ-028 Package gpio_arb_pkg SHALL hold the FSM state enum and the constants APB_ADDR_W=12, APB_DATA_W=32 and APB_STRB_W=4.
REQ-029 Round-robin grant SHALL be a sub-module gpio_rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant and index).

Verification
REQ-030 Single write: req 0 writes addr 0x000, data 0x12345678, strb 4'hF -> APB setup cycle N+1, access N+2, resp_valid[0] at N+3 with resp_err=0.
REQ-031 Single read: req 1 reads 0x204 while gpio_in_data=256'h90abcdef00000000 -> resp_rdata=0x90abcdef, resp_valid[1] only.
REQ-032 Contention: all 4 req_valid held high from reset -> grant order 0,1,2,3,0, with psel low for at least one cycle between transfers.
REQ-033 Wait states: pready held low 3 cycles -> penable high for 4 cycles, fields stable, single resp_valid.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=16): pready stuck low -> abort after 16 ACCESS cycles, resp_err=1, resp_rdata=0.
REQ-035 Reset mid-ACCESS: rst_n=0 for one cycle -> all outputs 0 next cycle, no resp_valid, requester 0 wins the next grant.
